// File: rtl/singleport_ram_p.sv
// Single-port byte-enabled RAM that clears itself to INIT_VAL after every reset before accepting requests.
// Define SPRAM_OUTREG_EN to add an output pipeline register (read latency 2 instead of 1).
module singleport_ram_p #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 6,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     data,
  input  logic [DATA_W/8-1:0]   be,
  output logic                  ready,
  output logic [DATA_W-1:0]     out,
  output logic                  out_valid,
  output logic                  init_done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int BE_W  = DATA_W/8;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                clr_p0;
  logic                accept_p0, rd_p0, wr_p0;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   out_p1_q;
  logic                vld_p1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_p0  = 1'b0;
    case (state_q)
      ST_INIT: begin
        clr_p0 = 1'b1;
        ptr_d  = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH-1)) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  assign ready     = (state_q == ST_RUN);
  assign init_done = (state_q == ST_RUN);
  assign accept_p0 = req & ready;
  assign rd_p0     = accept_p0 & ~we;
  assign wr_p0     = accept_p0 & we;

  // Stage p0 -> memory array: clear sweep during INIT, byte-masked writes during RUN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_p0) begin
        mem[ptr_q] <= INIT_VAL;
      end else if (wr_p0) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= data[8*b +: 8];
        end
      end
    end
  end

  // Stage p1: read data register; holds the last read value between reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      out_p1_q <= '0;
    end else begin
      vld_p1_q <= rd_p0;
      if (rd_p0) out_p1_q <= mem[addr];
    end
  end

`ifdef SPRAM_OUTREG_EN
  logic [DATA_W-1:0] out_p2_q;
  logic              vld_p2_q;

  // Stage p2: optional output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2_q <= 1'b0;
      out_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      out_p2_q <= out_p1_q;
    end
  end

  assign out       = out_p2_q;
  assign out_valid = vld_p2_q;
`else
  assign out       = out_p1_q;
  assign out_valid = vld_p1_q;
`endif

endmodule

// File: tb/tb_singleport_ram_p.sv
// Scoreboard bench for singleport_ram_p: an 8-bit default instance and a 16-bit instance for byte enables.
module tb_singleport_ram_p;

`ifdef SPRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int          cyc;
    logic [15:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [5:0]  addr;
  logic [7:0]  data;
  logic [0:0]  be;
  logic        ready, out_valid, init_done;
  logic [7:0]  out;

  logic        req16, we16;
  logic [5:0]  addr16;
  logic [15:0] data16;
  logic [1:0]  be16;
  logic        ready16, out_valid16, init_done16;
  logic [15:0] out16;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  exp_t        q[$];
  exp_t        q16[$];
  logic [7:0]  mem_m [64];

  singleport_ram_p dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .data(data), .be(be),
    .ready(ready), .out(out), .out_valid(out_valid), .init_done(init_done)
  );

  singleport_ram_p #(.DATA_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .req(req16), .we(we16), .addr(addr16), .data(data16), .be(be16),
    .ready(ready16), .out(out16), .out_valid(out_valid16), .init_done(init_done16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitors: every expected read must appear exactly on its cycle, nothing else may pulse
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      total++;
      if (out_valid !== 1'b1 || out !== q[0].d[7:0]) begin
        bad++;
        $display("FAIL rd8 cyc=%0d got out=%h vld=%b want out=%h vld=1", cyc, out, out_valid, q[0].d[7:0]);
      end
      void'(q.pop_front());
    end else if (out_valid !== 1'b0) begin
      total++; bad++;
      $display("FAIL rd8_spurious cyc=%0d got vld=%b want vld=0", cyc, out_valid);
    end
  end

  always @(negedge clk) begin
    if (q16.size() > 0 && q16[0].cyc == cyc) begin
      total++;
      if (out_valid16 !== 1'b1 || out16 !== q16[0].d) begin
        bad++;
        $display("FAIL rd16 cyc=%0d got out=%h vld=%b want out=%h vld=1", cyc, out16, out_valid16, q16[0].d);
      end
      void'(q16.pop_front());
    end else if (out_valid16 !== 1'b0) begin
      total++; bad++;
      $display("FAIL rd16_spurious cyc=%0d got vld=%b want vld=0", cyc, out_valid16);
    end
  end

  task automatic drv_rd(input logic [5:0] a, input logic [7:0] e);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a; data = '0; be = 1'b0;
    q.push_back('{cyc: cyc + LAT, d: {8'h00, e}});
  endtask

  task automatic drv_wr(input logic [5:0] a, input logic [7:0] d, input logic b);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; data = d; be = b;
    if (b) mem_m[a] = d;
  endtask

  task automatic drv_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req = 1'b0; we = 1'b0; req16 = 1'b0; we16 = 1'b0;
    end
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    drv_idle(3);
    total++; if (ready !== 1'b0)     begin bad++; $display("FAIL rst_ready got %b want 0", ready); end
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL rst_init_done got %b want 0", init_done); end
    total++; if (out !== 8'h00)      begin bad++; $display("FAIL rst_out got %h want 00", out); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (init_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 10) begin
        req = 1'b1; we = 1'b1; addr = 6'd10; data = 8'hee; be = 1'b1;
      end else begin
        req = 1'b0;
      end
      if (n == 32) begin
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL init_ready got %b want 0", ready); end
      end
    end
    total++; if (n != 64) begin bad++; $display("FAIL init_len got %0d want 64", n); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL run_ready got %b want 1", ready); end
    drv_rd(6'd2, 8'h00);
    drv_rd(6'd10, 8'h00);
    drv_idle(4);
  endtask

  task automatic test_back_to_back;
    drv_wr(6'd1, 8'ha1, 1'b1);
    drv_wr(6'd2, 8'hb2, 1'b1);
    drv_wr(6'd3, 8'hc3, 1'b1);
    drv_rd(6'd2, 8'hb2);
    drv_rd(6'd1, 8'ha1);
    drv_idle(4);
    total++; if (out !== 8'ha1) begin bad++; $display("FAIL hold_out got %h want a1", out); end
    drv_wr(6'd1, 8'h55, 1'b1);
    drv_idle(3);
    total++; if (out !== 8'ha1) begin bad++; $display("FAIL no_writethru got %h want a1", out); end
    drv_rd(6'd3, 8'hc3);
    drv_idle(3);
  endtask

  task automatic test_raw_and_be0;
    drv_wr(6'd20, 8'h3c, 1'b1);
    drv_rd(6'd20, 8'h3c);
    drv_wr(6'd20, 8'hff, 1'b0);
    drv_rd(6'd20, 8'h3c);
    drv_rd(6'd0, 8'h00);
    drv_rd(6'd63, 8'h00);
    drv_idle(4);
  endtask

  task automatic test_byte_enable;
    @(negedge clk);
    req16 = 1'b1; we16 = 1'b1; addr16 = 6'd5; data16 = 16'h1234; be16 = 2'b11;
    @(negedge clk);
    data16 = 16'habcd; be16 = 2'b10;
    @(negedge clk);
    we16 = 1'b0; data16 = '0; be16 = 2'b00;
    q16.push_back('{cyc: cyc + LAT, d: 16'hab34});
    @(negedge clk);
    addr16 = 6'd6;
    q16.push_back('{cyc: cyc + LAT, d: 16'h0000});
    drv_idle(4);
  endtask

  task automatic test_random;
    logic [5:0] a;
    logic [7:0] d;
    for (int i = 0; i < 40; i++) begin
      a = 6'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom_range(0, 255));
        drv_wr(a, d, 1'($urandom_range(0, 3) != 0));
      end else begin
        drv_rd(a, mem_m[a]);
      end
    end
    drv_idle(4);
  endtask

  task automatic test_reset_inflight;
    int n;
    drv_wr(6'd63, 8'hdf, 1'b1);
    drv_rd(6'd63, 8'hdf);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 6'd63; rst_n = 1'b0;
    @(negedge clk);
    req = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL inflight_vld got %b want 0", out_valid); end
    total++; if (init_done !== 1'b0) begin bad++; $display("FAIL inflight_init_done got %b want 0", init_done); end
    total++; if (out !== 8'h00)      begin bad++; $display("FAIL inflight_out got %h want 00", out); end
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
    wait_init(n);
    total++; if (n != 64) begin bad++; $display("FAIL reinit_len got %0d want 64", n); end
    drv_rd(6'd63, 8'h00);
    drv_rd(6'd1, 8'h00);
    drv_idle(4);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; data = '0; be = '0;
    req16 = 1'b0; we16 = 1'b0; addr16 = '0; data16 = '0; be16 = '0;
    test_reset;
    test_back_to_back;
    test_raw_and_be0;
    test_byte_enable;
    test_random;
    test_reset_inflight;
    total++;
    if (q.size() != 0 || q16.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got %0d/%0d pending want 0/0", q.size(), q16.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/singleport_ram_p.md
SINGLEPORT_RAM_P -- requirements
Module: singleport_ram_p

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, data word width in bits; legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL provide parameter ADDR_W, default 6, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL provide parameter INIT_VAL, default 0, DATA_W-bit value written to every word during initialisation.
REQ-004 SHALL provide port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL provide port rst_n, input, 1, synchronous active-low reset, sampled on the clk rising edge.
REQ-006 SHALL provide port req, input, 1, access request.
REQ-007 SHALL provide port we, input, 1, write when 1 and read when 0; qualified by req.
REQ-008 SHALL provide port addr, input, ADDR_W, word address.
REQ-009 SHALL provide port data, input, DATA_W, write data.
REQ-010 SHALL provide port be, input, DATA_W/8, byte enables; bit i covers data[8i+7:8i].
REQ-011 SHALL provide port ready, output, 1, accepting requests.
REQ-012 SHALL provide port out, output, DATA_W, read data.
REQ-013 SHALL provide port out_valid, output, 1, out carries fresh read data this cycle.
REQ-014 SHALL provide port init_done, output, 1, initialisation complete.

Function
REQ-015 SHALL implement a two-state FSM, INIT and RUN, plus an ADDR_W-bit clear pointer.
REQ-016 In INIT, SHALL write INIT_VAL to mem[ptr] each cycle and increment ptr; after writing ptr = DEPTH-1, SHALL enter RUN. INIT therefore lasts exactly DEPTH cycles.
REQ-017 ready and init_done SHALL be 0 in INIT and 1 in RUN; both SHALL rise together in the first RUN cycle.
REQ-018 A request is accepted only when req=1 and ready=1 at a clk edge; a req with ready=0 SHALL be dropped with no effect on memory or outputs.
REQ-019 An accepted write SHALL update only the bytes of mem[addr] whose be bit is 1; be=0 is accepted and changes nothing; out is unchanged and out_valid=0 on the following cycle.
REQ-020 An accepted read SHALL present mem[addr] on out and pulse out_valid=1 for exactly one cycle, one cycle after acceptance (latency 1).
REQ-021 out SHALL hold its last read value until the next read completes (no write-through).
REQ-022 The block is single-port with one access per cycle; a read issued the cycle after a write to the same address SHALL return the newly written data.
REQ-023 Back-to-back reads SHALL sustain one result per cycle with out_valid held high.
REQ-024 All DEPTH addresses are valid; no out-of-range case exists and the address does not wrap.

Reset
REQ-025 rst_n=0 at a clk edge SHALL force INIT, ptr=0, ready=0, init_done=0, out=0, out_valid=0.
REQ-026 A reset asserted mid-operation, including during INIT or with a read in flight, SHALL discard the in-flight result and restart a full initialisation; memory contents before reset are not preserved.
REQ-027 INIT writes SHALL begin in the first cycle with rst_n=1.

Configuration
REQ-028 Macro SPRAM_OUTREG_EN, when defined, SHALL add one output pipeline register on out and out_valid, making read latency 2 cycles while preserving one-per-cycle throughput.
REQ-029 When SPRAM_OUTREG_EN is defined, the added register SHALL also reset to 0.
REQ-030 Without SPRAM_OUTREG_EN, read latency SHALL be 1 cycle as in REQ-020.

Verification
REQ-031 Default parameters; release rst_n, then read addr 2 -> init_done rises exactly 64 cycles after release, and the read returns 8'h00 with a one-cycle out_valid pulse.
REQ-032 Write 8'ha1@1, 8'hb2@2, 8'hc3@3 with be=1, then read 2 and 1 back-to-back -> out = 8'hb2 then 8'ha1, with out_valid high for 2 consecutive cycles.
REQ-033 DATA_W=16: write 16'h1234@5 with be=2'b11, then write 16'habcd@5 with be=2'b10, then read 5 -> out = 16'hab34.
REQ-034 Default parameters: req write 8'hee@10 during INIT cycle 10, then read 10 after init_done -> returns 8'h00 (request dropped).
REQ-035 Write 8'hdf@63, read 63, then assert rst_n=0 on the cycle the read is accepted -> out_valid stays 0, init_done drops, and after re-initialisation a read of 63 returns 8'h00.
REQ-036 Repeat REQ-032 with SPRAM_OUTREG_EN defined -> identical data, each out_valid delayed by exactly one cycle.
